// File: rtl/step_sequencer_if.sv
// Command/status and step-drive bundle between a motion controller and step_sequencer.
// The controller owns the master side and the sequencer owns the slave side.
interface step_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             step_in;
    logic             dir;
    logic             enable;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] target;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pos_cnt;

    modport master (
        output step_in, dir, enable, start, abort, target,
        input  coil, busy, done, pos_cnt
    );

    modport slave (
        input  step_in, dir, enable, start, abort, target,
        output coil, busy, done, pos_cnt
    );
endinterface

// File: rtl/step_sequencer.sv
// Stepper phase sequencer: counts rising edges of the divider step clock and walks
// a 4-coil phase table forward or reverse for a commanded number of steps.
module step_sequencer #(
    parameter bit HALF_STEP = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk50,
    input  logic             rst,
    step_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] IDX_STEP = HALF_STEP ? 3'd1 : 3'd2;

    state_t           state_reg;
    logic [2:0]       idx_reg;
    logic             step_q_reg;
    logic [CNT_W-1:0] tgt_reg;
    logic [CNT_W-1:0] pos_cnt_reg;
    logic [3:0]       coil_reg;
    logic             busy_reg;
    logic             done_reg;

    // Even entries energise one coil, odd entries the two neighbouring coils.
    logic [3:0] phase_lut [8];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lut
            if (gi % 2 == 0) begin : g_single
                assign phase_lut[gi] = 4'(1 << (gi / 2));
            end else begin : g_pair
                assign phase_lut[gi] = 4'((1 << (gi / 2)) | (1 << (((gi / 2) + 1) % 4)));
            end
        end
    endgenerate

    logic             step_edge;
    logic [2:0]       idx_next;
    logic [CNT_W-1:0] pos_cnt_next;

    assign step_edge    = bus.step_in & ~step_q_reg;
    assign idx_next     = bus.dir ? (idx_reg + IDX_STEP) : (idx_reg - IDX_STEP);
    assign pos_cnt_next = pos_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 3'd0;
            step_q_reg  <= 1'b0;
            tgt_reg     <= '0;
            pos_cnt_reg <= '0;
            coil_reg    <= 4'b0000;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            step_q_reg <= bus.step_in;
            case (state_reg)
                ST_IDLE: begin
                    coil_reg <= 4'b0000;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        pos_cnt_reg <= '0;
                        if (bus.target != '0) begin
                            state_reg <= ST_RUN;
                            tgt_reg   <= bus.target;
                            busy_reg  <= 1'b1;
                            coil_reg  <= bus.enable ? phase_lut[idx_reg] : 4'b0000;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            coil_reg  <= phase_lut[idx_reg];
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        coil_reg  <= 4'b0000;
                    end else if (step_edge && bus.enable) begin
                        idx_reg     <= idx_next;
                        pos_cnt_reg <= pos_cnt_next;
                        coil_reg    <= phase_lut[idx_next];
                        if (pos_cnt_next == tgt_reg) begin
                            state_reg <= ST_DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        // Paused: edges are dropped and the coils released.
                        coil_reg <= bus.enable ? phase_lut[idx_reg] : 4'b0000;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    coil_reg  <= 4'b0000;
                end
            endcase
        end
    end

    assign bus.coil    = coil_reg;
    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.pos_cnt = pos_cnt_reg;
endmodule
